// File: rtl/divisor_prog_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and the 1 Hz default terminal count.
package divisor_prog_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [27:0] DIV_1HZ = 28'd99999999;

endpackage

// File: rtl/divisor_prog_if.sv
// Control/status bundle of divisor_prog; cnt is present only when DIVISOR_CNT_OUT_EN is defined.
interface divisor_prog_if #(
   parameter int WIDTH = 28
) ();

   logic             en;
   logic             load;
   logic [WIDTH-1:0] div_in;
   logic             tick;
   logic             clk_out;
   logic             load_pend;
`ifdef DIVISOR_CNT_OUT_EN
   logic [WIDTH-1:0] cnt;
`endif

`ifdef DIVISOR_CNT_OUT_EN
   modport master (output en, load, div_in, input tick, clk_out, load_pend, cnt);
   modport slave  (input en, load, div_in, output tick, clk_out, load_pend, cnt);
`else
   modport master (output en, load, div_in, input tick, clk_out, load_pend);
   modport slave  (input en, load, div_in, output tick, clk_out, load_pend);
`endif

endinterface

// File: rtl/divisor_cnt.sv
// Up-counter that wraps to zero at the terminal count; tc flags cnt==div. The cnt port exists only with DIVISOR_CNT_OUT_EN.
module divisor_cnt #(
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic             clr,
   input  logic [WIDTH-1:0] div,
   output logic             tc
`ifdef DIVISOR_CNT_OUT_EN
   ,
   output logic [WIDTH-1:0] cnt
`endif
);

   logic [WIDTH-1:0] cnt_reg;

   assign tc = (cnt_reg == div);

`ifdef DIVISOR_CNT_OUT_EN
   assign cnt = cnt_reg;
`endif

   // cnt never exceeds div, so equality alone closes the period.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (adv) begin
         cnt_reg <= tc ? '0 : cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/divisor_prog.sv
// Runtime-programmable clock divider: one-cycle tick, 50% clk_out, pause, boundary-aligned divisor reload.
// Optional debug count output enabled by defining DIVISOR_CNT_OUT_EN.
module divisor_prog
   import divisor_prog_pkg::*;
#(
   parameter int               WIDTH       = 28,
   parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(DIV_1HZ)
) (
   input  logic          clk,
   input  logic          rst,
   divisor_prog_if.slave bus
);

   logic [WIDTH-1:0] div_reg;
   logic [WIDTH-1:0] pend_div_reg;
   logic             load_pend_reg;
   logic             tick_reg;
   logic             clk_out_reg;
   state_t           state_reg;
   state_t           state_next;
   logic             tc;
   logic             apply_run;
   logic             apply_idle;

   always_comb begin
      state_next = bus.en ? ST_RUN : ST_IDLE;
      apply_run  = (state_next == ST_RUN) && tc && load_pend_reg;
      // A settled pause applies the pending divisor at once and restarts the period.
      apply_idle = (state_reg == ST_IDLE) && (state_next == ST_IDLE) && load_pend_reg;
   end

   divisor_cnt #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .adv (state_next == ST_RUN),
      .clr (apply_idle),
      .div (div_reg),
      .tc  (tc)
`ifdef DIVISOR_CNT_OUT_EN
      ,
      .cnt (bus.cnt)
`endif
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         div_reg       <= DIV_DEFAULT;
         pend_div_reg  <= '0;
         load_pend_reg <= 1'b0;
         tick_reg      <= 1'b0;
         clk_out_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         tick_reg  <= 1'b0;
         if ((state_next == ST_RUN) && tc) begin
            tick_reg    <= 1'b1;
            clk_out_reg <= ~clk_out_reg;
         end
         if (apply_run || apply_idle) begin
            div_reg       <= pend_div_reg;
            load_pend_reg <= 1'b0;
         end
         // A load on the apply edge becomes the next pending value.
         if (bus.load) begin
            pend_div_reg  <= bus.div_in;
            load_pend_reg <= 1'b1;
         end
      end
   end

   assign bus.tick      = tick_reg;
   assign bus.clk_out   = clk_out_reg;
   assign bus.load_pend = load_pend_reg;

endmodule

// File: tb/tb_divisor_prog.sv
// Directed bench for divisor_prog with WIDTH=8, DIV_DEFAULT=3: per-cycle vector table plus a reset-mid-period sequence.
module tb_divisor_prog;

   localparam int WIDTH = 8;

   logic clk;
   logic rst;

   divisor_prog_if #(.WIDTH(WIDTH)) bus ();

   divisor_prog #(
      .WIDTH       (WIDTH),
      .DIV_DEFAULT (8'd3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic             en;
      logic             load;
      logic [WIDTH-1:0] div_in;
      logic             tick;
      logic             clk_out;
      logic             lp;
      string            name;
   } vec_t;

   vec_t vec_q[$];
   int   n_tests;
   int   n_fail;

   function automatic void v(input logic r, input logic e, input logic l, input logic [WIDTH-1:0] d,
                             input logic t, input logic c, input logic p, input string nm);
      vec_t x;
      x.rst = r; x.en = e; x.load = l; x.div_in = d;
      x.tick = t; x.clk_out = c; x.lp = p; x.name = nm;
      vec_q.push_back(x);
   endfunction

   function automatic void vn(input int n, input logic e, input logic t, input logic c,
                              input logic p, input string nm);
      for (int k = 0; k < n; k++) v(1'b1, e, 1'b0, '0, t, c, p, nm);
   endfunction

   task automatic step(input vec_t x, input int idx);
      rst        = x.rst;
      bus.en     = x.en;
      bus.load   = x.load;
      bus.div_in = x.div_in;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.tick !== x.tick || bus.clk_out !== x.clk_out || bus.load_pend !== x.lp) begin
         n_fail++;
         $display("FAIL %s row %0d: tick=%b clk_out=%b load_pend=%b, required tick=%b clk_out=%b load_pend=%b",
                  x.name, idx, bus.tick, bus.clk_out, bus.load_pend, x.tick, x.clk_out, x.lp);
      end else begin
         $display("[TB] %s row %0d: tick=%b clk_out=%b load_pend=%b ok",
                  x.name, idx, bus.tick, bus.clk_out, bus.load_pend);
      end
   endtask

   task automatic check_cnt(input logic [WIDTH-1:0] exp, input string nm);
`ifdef DIVISOR_CNT_OUT_EN
      n_tests++;
      if (bus.cnt !== exp) begin
         n_fail++;
         $display("FAIL %s: cnt=%0d, required %0d", nm, bus.cnt, exp);
      end else begin
         $display("[TB] %s: cnt=%0d ok", nm, bus.cnt);
      end
`else
      $display("[TB] %s: cnt port absent, expected %0d not checked", nm, exp);
`endif
   endtask

   initial begin
      vec_t x;
      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b0;
      bus.en     = 1'b0;
      bus.load   = 1'b0;
      bus.div_in = '0;

      // reset
      v(1'b0, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, "reset");
      v(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "reset");
      // free run, div=3: ticks on edges 4,8,12,16,20
      for (int i = 1; i <= 20; i++)
         v(1'b1, 1'b1, 1'b0, '0, (i % 4) == 0, ((i / 4) % 2) == 1, 1'b0, "run");
      // pause at cnt=2 and resume
      vn(2, 1'b1, 1'b0, 1'b1, 1'b0, "pre_pause");
      vn(5, 1'b0, 1'b0, 1'b1, 1'b0, "paused");
      vn(1, 1'b1, 1'b0, 1'b1, 1'b0, "resume");
      vn(1, 1'b1, 1'b1, 1'b0, 1'b0, "resume_tick");
      vn(1, 1'b1, 1'b0, 1'b0, 1'b0, "resume");
      // load 7 at cnt=1: old period completes, then 8-cycle period
      v(1'b1, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b1, "load7");
      vn(1, 1'b1, 1'b0, 1'b0, 1'b1, "load7_pend");
      vn(1, 1'b1, 1'b1, 1'b1, 1'b0, "load7_boundary");
      vn(7, 1'b1, 1'b0, 1'b1, 1'b0, "div7");
      vn(1, 1'b1, 1'b1, 1'b0, 1'b0, "div7_tick");
      // load 0 while idle, then run: tick every cycle
      v(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "idle_load0");
      vn(1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_apply");
      vn(1, 1'b1, 1'b1, 1'b1, 1'b0, "div0");
      vn(1, 1'b1, 1'b1, 1'b0, 1'b0, "div0");
      vn(1, 1'b1, 1'b1, 1'b1, 1'b0, "div0");
      // back to div=3
      v(1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1, "load3");
      vn(1, 1'b1, 1'b1, 1'b1, 1'b0, "load3_apply");
      vn(1, 1'b1, 1'b0, 1'b1, 1'b0, "div3");
      // two loads in one period: last wins, 10-cycle periods
      v(1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 1'b1, "load5");
      v(1'b1, 1'b1, 1'b1, 8'd9, 1'b0, 1'b1, 1'b1, "load9");
      vn(1, 1'b1, 1'b1, 1'b0, 1'b0, "load9_boundary");
      vn(9, 1'b1, 1'b0, 1'b0, 1'b0, "div9");
      vn(1, 1'b1, 1'b1, 1'b1, 1'b0, "div9_tick");
      vn(7, 1'b1, 1'b0, 1'b1, 1'b0, "div9");
      // load coinciding with the boundary edge
      v(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, "load4");
      vn(1, 1'b1, 1'b0, 1'b1, 1'b1, "load4_pend");
      v(1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1, "load2_on_boundary");
      vn(4, 1'b1, 1'b0, 1'b0, 1'b1, "div4");
      vn(1, 1'b1, 1'b1, 1'b1, 1'b0, "div4_tick");
      vn(2, 1'b1, 1'b0, 1'b1, 1'b0, "div2");
      vn(1, 1'b1, 1'b1, 1'b0, 1'b0, "div2_tick");

      for (int i = 0; i < vec_q.size(); i++) step(vec_q[i], i);

      // reset mid-period with a pending load; reset beats en and load
      vec_q.delete();
      vn(2, 1'b1, 1'b0, 1'b0, 1'b0, "seq_div2");
      vn(1, 1'b1, 1'b1, 1'b1, 1'b0, "seq_div2_tick");
      v(1'b1, 1'b1, 1'b1, 8'd6, 1'b0, 1'b1, 1'b1, "seq_load6");
      for (int i = 0; i < vec_q.size(); i++) step(vec_q[i], i);
      check_cnt(8'd1, "seq_cnt_before_reset");

      x.rst = 1'b0; x.en = 1'b1; x.load = 1'b1; x.div_in = 8'd6;
      x.tick = 1'b0; x.clk_out = 1'b0; x.lp = 1'b0; x.name = "seq_mid_reset";
      step(x, 0);
      check_cnt(8'd0, "seq_cnt_after_reset");

      // default divisor restored: tick on the 4th edge after release
      x.rst = 1'b1; x.load = 1'b0; x.div_in = '0; x.name = "seq_post_reset";
      for (int i = 1; i <= 4; i++) begin
         x.tick    = (i == 4);
         x.clk_out = (i == 4);
         step(x, i);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
